// File: rtl/calc_seq.sv
// Sequencing controller for the calculator's shift-register datapath: drives the
// A/B register op codes and accumulator strobes for multiply, shift and load.
module calc_seq #(
  parameter int W  = 5,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    cmd,
  input  logic [CW-1:0] cnt,
  input  logic          b_zero,
  input  logic          b_lsb,
  output logic [1:0]    op_a,
  output logic [1:0]    op_b,
  output logic          acc_clr,
  output logic          acc_add,
  output logic          busy,
  output logic          done
);

  localparam int IW = $clog2(W + 1);

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;
  localparam logic [1:0] OP_SHL  = 2'b11;

  localparam logic [1:0] CMD_MUL = 2'b00;
  localparam logic [1:0] CMD_SHL = 2'b01;
  localparam logic [1:0] CMD_LD  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MUL,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t        state, state_n;
  logic [1:0]    cmd_q, cmd_n;
  logic [CW-1:0] rem, rem_n;
  logic [IW-1:0] iter, iter_n;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      cmd_q <= '0;
      rem   <= '0;
      iter  <= '0;
    end else begin
      state <= state_n;
      cmd_q <= cmd_n;
      rem   <= rem_n;
      iter  <= iter_n;
    end
  end

  always_comb begin
    state_n = state;
    cmd_n   = cmd_q;
    rem_n   = rem;
    iter_n  = iter;
    op_a    = OP_HOLD;
    op_b    = OP_HOLD;
    acc_clr = 1'b0;
    acc_add = 1'b0;
    busy    = (state != S_IDLE);
    done    = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          cmd_n   = cmd;
          rem_n   = cnt;
          iter_n  = '0;
          state_n = S_LOAD;
        end
      end

      S_LOAD: begin
        op_a = OP_LOAD;
        if (cmd_q == CMD_MUL || cmd_q == CMD_LD) op_b = OP_LOAD;
        acc_clr = (cmd_q == CMD_MUL);
        if (cmd_q == CMD_MUL)                   state_n = S_MUL;
        else if (cmd_q == CMD_LD || rem == '0)  state_n = S_DONE;
        else                                    state_n = S_SHIFT;
      end

      S_MUL: begin
        // Once B has drained to zero no further partial products remain.
        if (b_zero) begin
          state_n = S_DONE;
        end else begin
          acc_add = b_lsb;
          op_a    = OP_SHL;
          op_b    = OP_SHR;
          iter_n  = iter + 1'b1;
          if (iter == IW'(W - 1)) state_n = S_DONE;
        end
      end

      S_SHIFT: begin
        op_a  = (cmd_q == CMD_SHL) ? OP_SHL : OP_SHR;
        rem_n = rem - 1'b1;
        if (rem == CW'(1)) state_n = S_DONE;
      end

      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_calc_seq.sv
// Directed bench for calc_seq with a small shift-register datapath model feeding
// b_zero/b_lsb back; per-cycle output traces are checked against hand values.
module tb_calc_seq;
  localparam int W  = 5;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    cmd;
  logic [CW-1:0] cnt;
  logic          b_zero, b_lsb;
  logic [1:0]    op_a, op_b;
  logic          acc_clr, acc_add, busy, done;

  int errors = 0;
  int checks = 0;

  calc_seq #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd(cmd), .cnt(cnt),
    .b_zero(b_zero), .b_lsb(b_lsb), .op_a(op_a), .op_b(op_b),
    .acc_clr(acc_clr), .acc_add(acc_add), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // datapath model; A and acc are kept wide so products never truncate
  logic [W-1:0] b_reg = '0, b_in = '0;
  logic [9:0]   a_reg = '0, a_in = '0, acc = '0;

  always @(posedge clk) begin
    case (op_b)
      2'b01: b_reg <= b_in;
      2'b10: b_reg <= b_reg >> 1;
      2'b11: b_reg <= b_reg << 1;
      default: ;
    endcase
    case (op_a)
      2'b01: a_reg <= a_in;
      2'b10: a_reg <= a_reg >> 1;
      2'b11: a_reg <= a_reg << 1;
      default: ;
    endcase
    if (acc_clr)      acc <= '0;
    else if (acc_add) acc <= acc + a_reg;
  end

  assign b_zero = (b_reg == '0);
  assign b_lsb  = b_reg[0];

  logic [1:0] tr_opa [0:15];
  logic [1:0] tr_opb [0:15];
  logic       tr_clr [0:15];
  logic       tr_add [0:15];
  int         done_cyc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command and record outputs for cycle 1 (LOAD) up to the done cycle.
  task automatic run(input logic [1:0] c, input logic [CW-1:0] n);
    for (int i = 0; i < 16; i++) begin
      tr_opa[i] = 2'b00; tr_opb[i] = 2'b00; tr_clr[i] = 1'b0; tr_add[i] = 1'b0;
    end
    done_cyc = -1;
    start = 1'b1; cmd = c; cnt = n;
    tick();
    start = 1'b0;
    for (int i = 1; i < 16; i++) begin
      tr_opa[i] = op_a; tr_opb[i] = op_b; tr_clr[i] = acc_clr; tr_add[i] = acc_add;
      if (done) begin
        done_cyc = i;
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; cmd = 2'b00; cnt = '0;
    tick(); tick();
    checks++;
    if ({busy, done, acc_clr, acc_add} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got=%b want=0000", {busy, done, acc_clr, acc_add});
    end
    checks++;
    if ({op_a, op_b} !== 4'b0000) begin
      errors++; $display("FAIL reset_ops got=%b want=0000", {op_a, op_b});
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_mul_early_exit();
    a_in = 10'd3; b_in = 5'b01011;
    run(2'b00, 3'd0);
    checks++;
    if (done_cyc !== 7) begin errors++; $display("FAIL mul11_latency got=%0d want=7", done_cyc); end
    checks++;
    if ({tr_opa[1], tr_opb[1], tr_clr[1]} !== 5'b01011) begin
      errors++; $display("FAIL mul11_load got=%b want=01011", {tr_opa[1], tr_opb[1], tr_clr[1]});
    end
    for (int i = 2; i <= 5; i++) begin
      checks++;
      if ({tr_opa[i], tr_opb[i]} !== 4'b1110) begin
        errors++; $display("FAIL mul11_ops cyc=%0d got=%b want=1110", i, {tr_opa[i], tr_opb[i]});
      end
    end
    checks++;
    if ({tr_add[2], tr_add[3], tr_add[4], tr_add[5]} !== 4'b1101) begin
      errors++; $display("FAIL mul11_add_seq got=%b want=1101",
                         {tr_add[2], tr_add[3], tr_add[4], tr_add[5]});
    end
    checks++;
    if ({tr_opa[6], tr_opb[6], tr_add[6]} !== 5'b00000) begin
      errors++; $display("FAIL mul11_zero_cycle got=%b want=00000", {tr_opa[6], tr_opb[6], tr_add[6]});
    end
    checks++;
    if (acc !== 10'd33) begin errors++; $display("FAIL mul11_product got=%0d want=33", acc); end
  endtask

  task automatic test_mul_full_and_zero();
    a_in = 10'd3; b_in = 5'b10000;
    run(2'b00, 3'd0);
    checks++;
    if (done_cyc !== 7) begin errors++; $display("FAIL mul16_latency got=%0d want=7", done_cyc); end
    checks++;
    if ({tr_add[2], tr_add[3], tr_add[4], tr_add[5], tr_add[6]} !== 5'b00001) begin
      errors++; $display("FAIL mul16_add_seq got=%b want=00001",
                         {tr_add[2], tr_add[3], tr_add[4], tr_add[5], tr_add[6]});
    end
    checks++;
    if ({tr_opa[6], tr_opb[6]} !== 4'b1110) begin
      errors++; $display("FAIL mul16_last_iter got=%b want=1110", {tr_opa[6], tr_opb[6]});
    end
    checks++;
    if (acc !== 10'd48) begin errors++; $display("FAIL mul16_product got=%0d want=48", acc); end

    b_in = 5'b00000;
    run(2'b00, 3'd0);
    checks++;
    if (done_cyc !== 3) begin errors++; $display("FAIL mul0_latency got=%0d want=3", done_cyc); end
    checks++;
    if ({tr_add[2], tr_opa[2], tr_opb[2]} !== 5'b00000) begin
      errors++; $display("FAIL mul0_no_ops got=%b want=00000", {tr_add[2], tr_opa[2], tr_opb[2]});
    end
    checks++;
    if (acc !== 10'd0) begin errors++; $display("FAIL mul0_product got=%0d want=0", acc); end
  endtask

  task automatic test_shift();
    a_in = 10'd1;
    run(2'b01, 3'd3);
    checks++;
    if (done_cyc !== 5) begin errors++; $display("FAIL shl3_latency got=%0d want=5", done_cyc); end
    checks++;
    if ({tr_opa[1], tr_opa[2], tr_opa[3], tr_opa[4]} !== 8'b01111111) begin
      errors++; $display("FAIL shl3_ops got=%b want=01111111",
                         {tr_opa[1], tr_opa[2], tr_opa[3], tr_opa[4]});
    end
    checks++;
    if ({tr_opb[1], tr_opb[2], tr_clr[1]} !== 5'b00000) begin
      errors++; $display("FAIL shl3_b_idle got=%b want=00000", {tr_opb[1], tr_opb[2], tr_clr[1]});
    end
    checks++;
    if (a_reg !== 10'd8) begin errors++; $display("FAIL shl3_a got=%0d want=8", a_reg); end

    a_in = 10'd12;
    run(2'b10, 3'd2);
    checks++;
    if (done_cyc !== 4 || a_reg !== 10'd3) begin
      errors++; $display("FAIL shr2 got=cyc%0d/a%0d want=cyc4/a3", done_cyc, a_reg);
    end

    a_in = 10'd5;
    run(2'b10, 3'd0);
    checks++;
    if (done_cyc !== 2 || tr_opa[1] !== 2'b01) begin
      errors++; $display("FAIL shr0 got=cyc%0d/op%b want=cyc2/op01", done_cyc, tr_opa[1]);
    end
  endtask

  task automatic test_load();
    a_in = 10'd7; b_in = 5'd9;
    run(2'b11, 3'd5);
    checks++;
    if (done_cyc !== 2) begin errors++; $display("FAIL load_latency got=%0d want=2", done_cyc); end
    checks++;
    if ({tr_opa[1], tr_opb[1], tr_clr[1], tr_add[1]} !== 6'b010100) begin
      errors++; $display("FAIL load_ops got=%b want=010100",
                         {tr_opa[1], tr_opb[1], tr_clr[1], tr_add[1]});
    end
    checks++;
    if (a_reg !== 10'd7 || b_reg !== 5'd9) begin
      errors++; $display("FAIL load_regs got=%0d/%0d want=7/9", a_reg, b_reg);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] bv, dv, cv;
    bv = '0; dv = '0; cv = '0;
    start = 1'b1; cmd = 2'b11; cnt = '0;
    tick();
    for (int i = 0; i < 9; i++) begin
      bv[i] = busy; dv[i] = done; cv[i] = acc_clr | (op_b == 2'b10);
      // scramble cmd/cnt while busy; they must be ignored until IDLE
      if (busy) begin cmd = 2'b00; cnt = 3'd7; end
      else      begin cmd = 2'b11; cnt = 3'd0; end
      tick();
    end
    start = 1'b0;
    tick(); tick();
    checks++;
    if (bv !== 9'b011011011) begin errors++; $display("FAIL b2b_busy got=%b want=011011011", bv); end
    checks++;
    if (dv !== 9'b010010010) begin errors++; $display("FAIL b2b_done got=%b want=010010010", dv); end
    checks++;
    if (cv !== 9'b000000000) begin errors++; $display("FAIL b2b_cmd_leak got=%b want=000000000", cv); end
  endtask

  task automatic test_reset_mid_mul();
    int dn;
    a_in = 10'd3; b_in = 5'b01011;
    start = 1'b1; cmd = 2'b00; cnt = '0;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++;
    if ({op_a, op_b} !== 4'b1110) begin
      errors++; $display("FAIL rstmid_in_mul got=%b want=1110", {op_a, op_b});
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++;
    if ({busy, done, op_a, op_b, acc_clr, acc_add} !== 8'b0) begin
      errors++; $display("FAIL rstmid_idle got=%b want=00000000",
                         {busy, done, op_a, op_b, acc_clr, acc_add});
    end
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      if (done || busy) dn++;
      tick();
    end
    checks++;
    if (dn !== 0) begin errors++; $display("FAIL rstmid_stray_activity got=%0d want=0", dn); end
  endtask

  initial begin
    test_reset();
    test_mul_early_exit();
    test_mul_full_and_zero();
    test_shift();
    test_load();
    test_back_to_back();
    test_reset_mid_mul();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
